// File: rtl/vec_read_sequencer.sv
// Vector read sequencer: issues element reads, tracks the fixed-latency
// read-mux pipeline and streams results through a small output FIFO.
module vec_read_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sel_vec,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rd_enable,
  output logic              rd_ctrl,
  input  logic [15:0]       rd_result,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] L1 = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic              sel_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   popped;
  logic              pipe1;
  logic              pipe2;
  logic              ctrl_q;
  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic [CW:0]       level;
  logic              kill;
  logic              issue;
  logic              push;
  logic              pop;
  logic              last_hs;

  // Buffered plus in-flight elements; issuing only below depth
  // guarantees every returning read finds a free slot.
  assign level = {1'b0, count} + (CW+1)'(pipe1) + (CW+1)'(pipe2);

  assign kill    = abort && (state == ISSUE || state == DRAIN);
  assign issue   = (state == ISSUE) && !kill && (level < DEPTH_L);
  assign push    = pipe2 && !kill;
  assign pop     = out_valid && out_ready && !kill;
  assign last_hs = pop && out_last;

  assign mem_en    = issue;
  assign mem_addr  = base_q + issued[ADDR_W-1:0];
  assign rd_enable = pipe1;
  assign rd_ctrl   = ctrl_q;
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo_mem[rptr] : '0;
  assign out_last  = out_valid && (popped == len_q - L1);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sel_q  <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
      issued <= '0;
      popped <= '0;
    end else begin
      if (pop) popped <= popped + L1;
      unique case (state)
        IDLE: begin
          if (start) begin
            sel_q  <= sel_vec;
            base_q <= base_addr;
            len_q  <= len;
            issued <= '0;
            popped <= '0;
            state  <= (len != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          if (kill) begin
            state <= IDLE;
          end else if (issue) begin
            issued <= issued + L1;
            if (issued == len_q - L1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (kill) state <= IDLE;
          else if (last_hs) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe1  <= 1'b0;
      pipe2  <= 1'b0;
      ctrl_q <= 1'b0;
    end else begin
      pipe1  <= issue;
      pipe2  <= pipe1 && !kill;
      ctrl_q <= issue && sel_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (kill) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= rd_result;
  end

endmodule

// File: doc/vec_read_sequencer.md
VEC_READ_SEQUENCER -- requirements
Module: vec_read_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the memory address width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output buffer depth (power of two, >=4).

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: start-request pulse.
REQ-006 The block SHALL have port sel_vec, input, 1 bit: 1 = vector A, 0 = vector B.
REQ-007 The block SHALL have port base_addr, input, ADDR_W bits: first element address.
REQ-008 The block SHALL have port len, input, ADDR_W+1 bits: element count, 0..2^ADDR_W.
REQ-009 The block SHALL have port abort, input, 1 bit: cancel the current transfer.
REQ-010 The block SHALL have port mem_en, output, 1 bit: memory read enable for both banks.
REQ-011 The block SHALL have port mem_addr, output, ADDR_W bits: memory read address.
REQ-012 The block SHALL have port rd_enable, output, 1 bit: drives the read-mux register enable.
REQ-013 The block SHALL have port rd_ctrl, output, 1 bit: drives the read-mux bank select (1 = A).
REQ-014 The block SHALL have port rd_result, input, 16 bits: registered read-mux output.
REQ-015 The block SHALL have port out_data, output, 16 bits: streamed element.
REQ-016 The block SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-017 The block SHALL have port out_ready, input, 1 bit: consumer ready.
REQ-018 The block SHALL have port out_last, output, 1 bit: marks the final element.
REQ-019 The block SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-020 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-021 The block SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-022 In IDLE, start=1 SHALL latch sel_vec, base_addr and len; the FSM SHALL go to ISSUE if len>0, else to DONE.
REQ-023 start SHALL be ignored in every state other than IDLE.
REQ-024 In ISSUE, a read SHALL be issued in a cycle (mem_en=1, mem_addr=base+k, k=0..len-1) only when fifo_count + inflight < FIFO_DEPTH.
REQ-025 mem_addr SHALL wrap modulo 2^ADDR_W.
REQ-026 The read pipeline SHALL have fixed latency: issue in cycle t; rd_enable=1 and rd_ctrl=latched sel in t+1; rd_result written into the FIFO at the end of t+2.
REQ-027 rd_enable SHALL be 0 in every cycle not exactly one cycle after an issue.
REQ-028 inflight (0..2) SHALL count issued reads not yet written to the FIFO.
REQ-029 After the len-th issue the FSM SHALL go to DRAIN.
REQ-030 The FSM SHALL leave DRAIN for DONE in the cycle the last element handshakes (out_valid & out_ready & out_last).
REQ-031 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-032 out_valid SHALL equal FIFO non-empty; out_data SHALL be the FIFO head; the head SHALL pop on out_valid & out_ready.
REQ-033 A FIFO push and pop in the same cycle SHALL both occur, leaving count unchanged.
REQ-034 out_last SHALL be 1 only while the head is element len-1.
REQ-035 The FIFO SHALL never overflow; a push to a full FIFO is a design error that verification must flag.
REQ-036 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-037 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-038 abort=1 in ISSUE or DRAIN SHALL stop issuing immediately, discard in-flight reads, flush the FIFO and go to IDLE next cycle with no done pulse.
REQ-039 abort SHALL be ignored in IDLE and DONE.
REQ-040 abort SHALL take priority over every other event in the same cycle.

Reset
REQ-041 reset=0 SHALL asynchronously force state IDLE, inflight=0, FIFO empty and the element counter to 0.
REQ-042 During reset, mem_en, rd_enable, rd_ctrl, out_valid, out_last, busy and done SHALL be 0, and mem_addr and out_data SHALL be 0.
REQ-043 Reset asserted mid-transfer SHALL drop all elements; after release the block SHALL be idle and accept a new start.

Verification
REQ-044 Basic A read: base=0, len=4, sel=1, out_ready held 1 -> mem_addr 0,1,2,3 on consecutive cycles; out_data = A[0..3] with first out_valid 3 cycles after first issue; out_last on the 4th element; done pulses the next cycle.
REQ-045 Backpressure: len=8, sel=0, out_ready low for 10 cycles -> exactly 4 issues; issuing stalls; no element is lost or duplicated when out_ready rises; B[0..7] delivered in order.
REQ-046 Wrap: ADDR_W=10, base=1022, len=4 -> mem_addr 1022,1023,0,1.
REQ-047 Zero length: start with len=0 -> no mem_en, no out_valid; busy=1 for one cycle with done=1, then IDLE.
REQ-048 Abort: abort at the 3rd issue of len=16 -> next cycle busy=0, out_valid=0, no done; a new start len=2 delivers exactly 2 correct elements.
REQ-049 Reset mid-transfer: reset=0 asynchronously in DRAIN -> all outputs 0 immediately; start ignored while busy, checked before the reset.
